// File: rtl/sram_access_ctrl_if.sv
// Request/response handshake bundle between a requester and sram_access_ctrl.
interface sram_access_ctrl_if;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned CONF_W = 3;
  localparam int unsigned DATA_W = 32;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [CONF_W-1:0] req_conf;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_conf, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_conf, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_access_ctrl.sv
// Sequences one bit-addressed SRAM access: precharge, wordline, optional sense, response.
module sram_access_ctrl #(
  parameter int unsigned PRE_CYCLES   = 1,
  parameter int unsigned SENSE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  sram_access_ctrl_if.slave   bus,
  output logic [4:0]          bl_addr,
  output logic [2:0]          bl_conf,
  input  logic [31:0]         bl_mask,
  output logic                sram_pre,
  output logic [31:0]         sram_wl,
  output logic                sram_we,
  output logic [31:0]         sram_wmask,
  output logic [31:0]         sram_din,
  output logic                sram_sae,
  input  logic [31:0]         sram_dout
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {IDLE, PRE, ACC, SENSE, RESP} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [4:0]        row_q;
  logic [4:0]        off_q;
  logic [2:0]        conf_q;
  logic [DATA_W-1:0] wdata_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              sram_pre_q;
  logic [DATA_W-1:0] sram_wl_q;
  logic              sram_we_q;
  logic [DATA_W-1:0] wmask_q;
  logic [DATA_W-1:0] sram_din_q;
  logic              sram_sae_q;

  // Right-justified data mask for an access of 2^conf bits.
  function automatic logic [DATA_W-1:0] width_mask(input logic [2:0] conf);
    logic [DATA_W-1:0] m;
    case (conf)
      3'd0:    m = 32'h0000_0001;
      3'd1:    m = 32'h0000_0003;
      3'd2:    m = 32'h0000_000F;
      3'd3:    m = 32'h0000_00FF;
      3'd4:    m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  // Clears the offset bits below the access width (natural alignment).
  function automatic logic [4:0] align_mask(input logic [2:0] conf);
    logic [4:0] m;
    case (conf)
      3'd0:    m = 5'h1F;
      3'd1:    m = 5'h1E;
      3'd2:    m = 5'h1C;
      3'd3:    m = 5'h18;
      3'd4:    m = 5'h10;
      default: m = 5'h00;
    endcase
    return m;
  endfunction

  // Access sequencer; every output is a register updated on state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      row_q       <= '0;
      off_q       <= '0;
      conf_q      <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      sram_pre_q  <= 1'b0;
      sram_wl_q   <= '0;
      sram_we_q   <= 1'b0;
      wmask_q     <= '0;
      sram_din_q  <= '0;
      sram_sae_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            req_ready_q <= 1'b0;
            we_q        <= bus.req_we;
            row_q       <= bus.req_addr[9:5];
            off_q       <= bus.req_addr[4:0] & align_mask(bus.req_conf);
            conf_q      <= bus.req_conf;
            wdata_q     <= bus.req_wdata;
            if (bus.req_conf <= 3'd5) begin
              state_q    <= PRE;
              sram_pre_q <= 1'b1;
              cnt_q      <= CNT_W'(PRE_CYCLES - 1);
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        PRE: begin
          if (cnt_q == '0) begin
            state_q    <= ACC;
            sram_pre_q <= 1'b0;
            wmask_q    <= bl_mask;
            sram_wl_q  <= DATA_W'(1) << row_q;
            sram_we_q  <= we_q;
            sram_din_q <= (wdata_q & width_mask(conf_q)) << off_q;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        ACC: begin
          sram_we_q  <= 1'b0;
          wmask_q    <= '0;
          sram_din_q <= '0;
          if (we_q) begin
            state_q     <= RESP;
            sram_wl_q   <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
          end else begin
            state_q    <= SENSE;
            sram_sae_q <= 1'b1;
            cnt_q      <= CNT_W'(SENSE_CYCLES - 1);
          end
        end
        SENSE: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            sram_sae_q  <= 1'b0;
            sram_wl_q   <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= (sram_dout >> off_q) & width_mask(conf_q);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bl_addr       = off_q;
  assign bl_conf       = conf_q;
  assign sram_pre      = sram_pre_q;
  assign sram_wl       = sram_wl_q;
  assign sram_we       = sram_we_q;
  assign sram_wmask    = wmask_q;
  assign sram_din      = sram_din_q;
  assign sram_sae      = sram_sae_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Randomized bench for sram_access_ctrl against a cycle-count reference model.
module tb_sram_access_ctrl;
  localparam int unsigned PRE = 2;
  localparam int unsigned SEN = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  bl_addr;
  logic [2:0]  bl_conf;
  logic [31:0] bl_mask;
  logic        sram_pre, sram_we, sram_sae;
  logic [31:0] sram_wl, sram_wmask, sram_din, sram_dout;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  sram_access_ctrl_if bus ();

  sram_access_ctrl #(.PRE_CYCLES(PRE), .SENSE_CYCLES(SEN)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .bl_addr(bl_addr), .bl_conf(bl_conf), .bl_mask(bl_mask),
    .sram_pre(sram_pre), .sram_wl(sram_wl), .sram_we(sram_we),
    .sram_wmask(sram_wmask), .sram_din(sram_din), .sram_sae(sram_sae),
    .sram_dout(sram_dout)
  );

  // Reference mask of 2^conf bits: 2^width - 1, computed in 64 bits.
  function automatic logic [31:0] ref_mask(input logic [2:0] c);
    longint unsigned width;
    longint unsigned m;
    width = longint'(1) << c;
    m = (longint'(1) << width) - 1;
    return 32'(m);
  endfunction

  // Behavioural bitline-mask generator.
  assign bl_mask = ref_mask(bl_conf) << bl_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_pre"}, 32'(sram_pre), 32'd0);
    check_eq({tag, "_wl"}, sram_wl, 32'd0);
    check_eq({tag, "_we"}, 32'(sram_we), 32'd0);
    check_eq({tag, "_wmask"}, sram_wmask, 32'd0);
    check_eq({tag, "_din"}, sram_din, 32'd0);
    check_eq({tag, "_sae"}, 32'(sram_sae), 32'd0);
    check_eq({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check_eq({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic wait_ready();
    int w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq("ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  // One full transaction: accept, per-cycle array checks, response hold, exit.
  task automatic run_txn(input logic we, input logic [9:0] addr, input logic [2:0] conf,
                         input logic [31:0] wdata, input logic [31:0] dout,
                         input int hold, input bit probe_exit);
    bit          legal;
    int unsigned lat, width;
    logic [4:0]  off;
    logic [31:0] wm, exp_rd, exp_wl;
    bit          in_pre, in_acc, in_sense;
    legal  = (conf <= 3'd5);
    width  = legal ? (1 << conf) : 1;
    off    = legal ? 5'(addr[4:0] - (addr[4:0] % width)) : 5'd0;
    wm     = legal ? ref_mask(conf) : 32'd0;
    exp_rd = (legal && !we) ? ((dout >> off) & wm) : 32'd0;
    lat    = !legal ? 1 : (we ? PRE + 2 : PRE + 2 + SEN);
    exp_wl = 32'd1 << addr[9:5];

    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_conf  = conf;
    bus.req_wdata = wdata;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    for (int unsigned k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_addr  = 10'($urandom);
        bus.req_conf  = 3'($urandom);
        bus.req_wdata = $urandom;
      end
      sram_dout = (legal && !we && k == PRE + 1 + SEN) ? dout : $urandom;
      in_pre   = legal && (k <= PRE);
      in_acc   = legal && (k == PRE + 1);
      in_sense = legal && !we && (k >= PRE + 2) && (k <= PRE + 1 + SEN);
      check_eq("req_ready_busy", 32'(bus.req_ready), 32'd0);
      check_eq("sram_pre", 32'(sram_pre), 32'(in_pre));
      check_eq("sram_wl", sram_wl, (in_acc || in_sense) ? exp_wl : 32'd0);
      check_eq("sram_we", 32'(sram_we), 32'(in_acc && we));
      check_eq("sram_wmask", sram_wmask, in_acc ? (wm << off) : 32'd0);
      check_eq("sram_din", sram_din, in_acc ? ((wdata & wm) << off) : 32'd0);
      check_eq("sram_sae", 32'(sram_sae), 32'(in_sense));
      check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(k == lat));
      if (legal) begin
        check_eq("bl_addr", 32'(bl_addr), 32'(off));
        check_eq("bl_conf", 32'(bl_conf), 32'(conf));
      end
    end
    check_eq("rsp_rdata", bus.rsp_rdata, exp_rd);
    check_eq("rsp_err", 32'(bus.rsp_err), 32'(!legal));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check_eq("hold_rdata", bus.rsp_rdata, exp_rd);
      check_eq("hold_err", 32'(bus.rsp_err), 32'(!legal));
      check_eq("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    if (probe_exit) begin
      bus.req_valid = 1'b1;
      bus.req_conf  = 3'd0;
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b0;
    check_eq("exit_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("exit_ready", 32'(bus.req_ready), 32'd1);
    check_eq("exit_no_accept", 32'(sram_pre), 32'd0);
  endtask

  // Read aborted by reset during its first sense cycle.
  task automatic reset_mid_sense();
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 10'($urandom);
    bus.req_conf  = 3'd2;
    bus.req_wdata = $urandom;
    @(posedge clk);
    for (int unsigned k = 1; k <= PRE + 2; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
    check_eq("abort_in_sense", 32'(sram_sae), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_quiet("abort");
    check_eq("abort_err", 32'(bus.rsp_err), 32'd0);
    check_eq("abort_rdata", bus.rsp_rdata, 32'd0);
    check_eq("abort_bl_addr", 32'(bl_addr), 32'd0);
    check_eq("abort_bl_conf", 32'(bl_conf), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("post_abort");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_conf  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    sram_dout     = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check_eq("reset_err", 32'(bus.rsp_err), 32'd0);
    check_eq("reset_rdata", bus.rsp_rdata, 32'd0);
    check_eq("reset_bl_addr", 32'(bl_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("ready_after_reset", 32'(bus.req_ready), 32'd1);

    run_txn(1'b1, {5'd3, 5'd21}, 3'd3, 32'h0000_00A5, $urandom, 0, 1'b0);
    run_txn(1'b0, {5'd7, 5'd21}, 3'd0, $urandom, 32'h0020_0000, 0, 1'b0);
    run_txn(1'b0, 10'($urandom), 3'd5, $urandom, 32'hDEAD_BEEF, 1, 1'b0);
    run_txn(1'b1, 10'($urandom), 3'd6, $urandom, $urandom, 0, 1'b1);
    run_txn(1'b0, 10'($urandom), 3'd4, $urandom, $urandom, 5, 1'b1);
    reset_mid_sense();

    for (int n = 0; n < 150; n++) begin
      run_txn(1'($urandom), 10'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom,
              int'($urandom_range(0, 5)), 1'($urandom));
      if ($urandom_range(0, 19) == 0) reset_mid_sense();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
